// File: rtl/debug_unit.sv
// Host debug controller: decodes UART command bytes, runs or steps the
// pipeline, then streams PC, cycle count, registers and data memory out MSB-first.
// Ports:
//   i_clock, i_reset   : clock, async active-high reset
//   i_rx_*             : received command byte and its strobe
//   o_tx_*, i_tx_done  : byte-out handshake with the UART transmitter
//   o_pipe_valid/reset : pipeline advance enable and pipeline reset
//   i_halt, i_pc       : pipeline status
//   o_rf_addr/i_rf_data: register file debug read port (1-cycle latency)
//   o_dm_addr/i_dm_data: data memory debug read port (1-cycle latency)
module debug_unit #(
  parameter int NB_REG        = 32,
  parameter int NB_BYTE       = 8,
  parameter int NB_REG_ADDR   = 5,
  parameter int REGFILE_DEPTH = 32,
  parameter int NB_DM_ADDR    = 4,
  parameter int N_DM_WORDS    = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_BYTE-1:0]     i_rx_data,
  input  logic                   i_rx_valid,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_pipe_valid,
  output logic                   o_pipe_reset,
  input  logic                   i_halt,
  input  logic [NB_REG-1:0]      i_pc,
  output logic [NB_REG_ADDR-1:0] o_rf_addr,
  input  logic [NB_REG-1:0]      i_rf_data,
  output logic [NB_DM_ADDR-1:0]  o_dm_addr,
  input  logic [NB_REG-1:0]      i_dm_data
);

  localparam int W_TOTAL = 2 + REGFILE_DEPTH + N_DM_WORDS;
  localparam int NB_W    = $clog2(W_TOTAL);
  localparam int RF_LO   = 2;
  localparam int DM_LO   = 2 + REGFILE_DEPTH;

  localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h63);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h73);
  localparam logic [NB_BYTE-1:0] CMD_RST  = NB_BYTE'(8'h72);

  typedef enum logic [2:0] {
    IDLE, RUN, STEP, RST, ADDR, CAPT, TX, TXWAIT
  } state_t;

  state_t                 state_q;
  logic [31:0]            cnt_q;
  logic [NB_W-1:0]        w_q;
  logic [2:0]             bcnt_q;
  logic [NB_REG-1:0]      shift_q;
  logic [NB_BYTE-1:0]     tx_data_q;
  logic                   tx_start_q;
  logic                   pv_q;
  logic                   pr_q;
  logic [NB_REG_ADDR-1:0] rf_addr_q;
  logic [NB_DM_ADDR-1:0]  dm_addr_q;

  logic [NB_W-1:0]        w_d;
  logic [NB_REG-1:0]      cap_d;
  logic [NB_REG_ADDR-1:0] rf_addr_d;
  logic [NB_DM_ADDR-1:0]  dm_addr_d;

  always_comb begin
    w_d       = w_q + 1'b1;
    rf_addr_d = NB_REG_ADDR'(w_d - NB_W'(RF_LO));
    dm_addr_d = NB_DM_ADDR'(w_d - NB_W'(DM_LO));
    cap_d     = i_dm_data;
    if (w_q == NB_W'(0))
      cap_d = i_pc;
    else if (w_q == NB_W'(1))
      cap_d = cnt_q;
    else if (w_q < NB_W'(DM_LO))
      cap_d = i_rf_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      w_q        <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      pv_q       <= 1'b0;
      pr_q       <= 1'b0;
      rf_addr_q  <= '0;
      dm_addr_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      pr_q       <= 1'b0;
      // every cycle the pipeline was enabled counts as executed
      if (pv_q)
        cnt_q <= cnt_q + 32'd1;
      unique case (state_q)
        IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_RST) begin
              pr_q    <= 1'b1;
              state_q <= RST;
            end else if (i_rx_data == CMD_RUN ||
                         i_rx_data == CMD_STEP) begin
              w_q <= '0;
              // already halted: dump without executing anything
              if (i_halt) begin
                state_q <= ADDR;
              end else begin
                pv_q    <= 1'b1;
                state_q <= (i_rx_data == CMD_RUN) ? RUN : STEP;
              end
            end
          end
        end
        RUN: begin
          if (i_halt) begin
            pv_q    <= 1'b0;
            state_q <= ADDR;
          end
        end
        STEP: begin
          pv_q    <= 1'b0;
          state_q <= ADDR;
        end
        RST: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        ADDR: state_q <= CAPT;
        CAPT: begin
          // start is registered so it is high during the TX cycle itself
          shift_q    <= cap_d;
          bcnt_q     <= '0;
          tx_data_q  <= cap_d[NB_REG-1 -: NB_BYTE];
          tx_start_q <= 1'b1;
          state_q    <= TX;
        end
        TX: state_q <= TXWAIT;
        TXWAIT: begin
          if (i_tx_done) begin
            shift_q <= shift_q << NB_BYTE;
            bcnt_q  <= bcnt_q + 3'd1;
            if (bcnt_q != 3'd3) begin
              tx_data_q  <= shift_q[NB_REG-NB_BYTE-1 -: NB_BYTE];
              tx_start_q <= 1'b1;
              state_q    <= TX;
            end else if (w_q < NB_W'(W_TOTAL - 1)) begin
              // present the next word's read address during ADDR
              w_q <= w_d;
              if (w_d < NB_W'(DM_LO))
                rf_addr_q <= rf_addr_d;
              else
                dm_addr_q <= dm_addr_d;
              state_q <= ADDR;
            end else begin
              w_q       <= '0;
              rf_addr_q <= '0;
              dm_addr_q <= '0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = tx_start_q;
  assign o_pipe_valid = pv_q;
  assign o_pipe_reset = pr_q;
  assign o_rf_addr    = rf_addr_q;
  assign o_dm_addr    = dm_addr_q;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: command decode, run/step/reset,
// dump contents and ordering, dropped bytes and async abort.
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        pv;
  logic        pr;
  logic        halt;
  logic [31:0] pc;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [3:0]  dm_addr;
  logic [31:0] dm_data;

  logic [31:0] rf [32];
  logic [31:0] dm [16];

  logic [7:0]  bytes [$];
  int          nvalid;
  int          nreset;
  int          dly;
  int          total;
  int          bad;
  int          vc;
  int          nsave;

  always #5 clk = ~clk;

  debug_unit dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_done    (tx_done),
    .o_pipe_valid (pv),
    .o_pipe_reset (pr),
    .i_halt       (halt),
    .i_pc         (pc),
    .o_rf_addr    (rf_addr),
    .i_rf_data    (rf_data),
    .o_dm_addr    (dm_addr),
    .i_dm_data    (dm_data)
  );

  always @(posedge clk) begin
    rf_data <= rf[rf_addr];
    dm_data <= dm[dm_addr];
  end

  // transmitter model: done pulse 3 cycles after each start
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      dly = 0;
    end else begin
      if (dly > 0) begin
        dly--;
        if (dly == 0) tx_done = 1'b1;
      end
      if (tx_start) begin
        bytes.push_back(tx_data);
        dly = 3;
      end
      if (pv) nvalid++;
      if (pr) nreset++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    if (i + 3 < bytes.size())
      return {bytes[i], bytes[i+1], bytes[i+2], bytes[i+3]};
    return 'x;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic clear();
    bytes.delete();
    nvalid = 0;
    nreset = 0;
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (bytes.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_dump(input string tag);
    wait_bytes(200);
    repeat (30) @(negedge clk);
    chk(tag, 32'(bytes.size()), 32'd200);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    dly      = 0;
    tx_done  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    halt     = 1'b0;
    pc       = 32'h0000_0010;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[5] = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) dm[i] = 32'hA000_0000 + 32'(i * 17);
    clear();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pv", {31'd0, pv}, 32'd0);
    chk("rst_pr", {31'd0, pr}, 32'd0);
    chk("rst_txs", {31'd0, tx_start}, 32'd0);
    chk("rst_txd", {24'd0, tx_data}, 32'd0);
    chk("rst_addr", {23'd0, rf_addr, dm_addr}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single step from counter 0
    clear();
    send(8'h73);
    wait_dump("step_len");
    chk("step_valid", 32'(nvalid), 32'd1);
    chk("step_pc", word_at(0), 32'h0000_0010);
    chk("step_cnt", word_at(4), 32'h0000_0001);
    chk("step_r0", word_at(8), 32'h1000_0000);
    chk("step_r5", word_at(28), 32'hDEAD_BEEF);
    chk("step_r31", word_at(132), 32'h1000_001F);
    chk("step_m0", word_at(136), 32'hA000_0000);
    chk("step_m15", word_at(196), 32'hA000_00FF);

    // pipeline reset, then a step reports count 1
    clear();
    send(8'h72);
    repeat (20) @(negedge clk);
    chk("prst_pulse", 32'(nreset), 32'd1);
    chk("prst_tx", 32'(bytes.size()), 32'd0);
    chk("prst_valid", 32'(nvalid), 32'd0);
    clear();
    send(8'h73);
    wait_dump("prst_len");
    chk("prst_cnt", word_at(4), 32'h0000_0001);

    // continuous run, halt in the 100th valid cycle
    send(8'h72);
    repeat (5) @(negedge clk);
    clear();
    pc = 32'h0000_0190;
    send(8'h63);
    vc = 0;
    for (int t = 0; t < 500; t++) begin
      if (pv) begin
        vc++;
        if (vc == 100) begin
          halt = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
    wait_dump("run_len");
    chk("run_valid", 32'(nvalid), 32'd100);
    chk("run_pc", word_at(0), 32'h0000_0190);
    chk("run_cnt", word_at(4), 32'h0000_0064);
    chk("run_r5", word_at(28), 32'hDEAD_BEEF);

    // run requested while already halted
    clear();
    send(8'h63);
    wait_dump("hlt_len");
    chk("hlt_valid", 32'(nvalid), 32'd0);
    chk("hlt_cnt", word_at(4), 32'h0000_0064);

    // byte during dump is dropped
    halt = 1'b0;
    send(8'h72);
    repeat (5) @(negedge clk);
    clear();
    send(8'h73);
    wait_bytes(20);
    send(8'h73);
    wait_dump("drop_len");
    chk("drop_valid", 32'(nvalid), 32'd1);
    chk("drop_cnt", word_at(4), 32'h0000_0001);

    // unknown byte in IDLE
    clear();
    send(8'h41);
    repeat (60) @(negedge clk);
    chk("unk_tx", 32'(bytes.size()), 32'd0);
    chk("unk_act", 32'(nvalid + nreset), 32'd0);

    // async reset mid-run
    clear();
    send(8'h63);
    repeat (20) @(negedge clk);
    chk("arun_pv", {31'd0, pv}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arun_pv0", {31'd0, pv}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear();
    repeat (100) @(negedge clk);
    chk("arun_tx", 32'(bytes.size()), 32'd0);
    chk("arun_valid", 32'(nvalid), 32'd0);

    // async reset mid-dump
    clear();
    send(8'h73);
    wait_bytes(10);
    rst = 1'b1;
    #1;
    chk("adump_txs", {31'd0, tx_start}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nsave = bytes.size();
    repeat (100) @(negedge clk);
    chk("adump_tx", 32'(bytes.size()), 32'(nsave));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
